alu_cmd_sequencer: RTL and testbench



---
 rtl/alu_cmd_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: button/switch front-end that loads A, B and the opcode,
// holds them on the ALU for ALU_LAT cycles, then captures ALU_Out/CarryOut.
// Ports:
//   clk, rst            clock and asynchronous active-high reset
//   sw                  switch data used for A, B and the opcode
//   btn_load, btn_clear raw level buttons (synchronized in here)
//   ALU_Out, CarryOut   ALU result inputs
//   A, B, ALU_Sel       registered operands and opcode driven to the ALU
//   result, result_carry, result_valid  captured result for the display
//   op_count            completed-operation counter (wraps at 255)
//   state, busy         FSM state code and EXEC indicator for the LEDs
module alu_cmd_sequencer #(
    parameter int DATA_W  = 8,
    parameter int SEL_W   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] sw,
    input  logic              btn_load,
    input  logic              btn_clear,
    input  logic [DATA_W-1:0] ALU_Out,
    input  logic              CarryOut,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic [SEL_W-1:0]  ALU_Sel,
    output logic [DATA_W-1:0] result,
    output logic              result_carry,
    output logic              result_valid,
    output logic [7:0]        op_count,
    output logic [2:0]        state,
    output logic              busy
);

    localparam logic [2:0] LOAD_A   = 3'd0;
    localparam logic [2:0] LOAD_B   = 3'd1;
    localparam logic [2:0] LOAD_SEL = 3'd2;
    localparam logic [2:0] EXEC     = 3'd3;
    localparam logic [2:0] DONE     = 3'd4;

    // Counter starts at ALU_LAT-1 so capture lands ALU_LAT edges after entry.
    localparam logic [3:0] WAIT_INIT = 4'(ALU_LAT - 1);

    logic ld_sync1_q, ld_sync1_d;
    logic ld_sync2_q, ld_sync2_d;
    logic ld_prev_q,  ld_prev_d;
    logic cl_sync1_q, cl_sync1_d;
    logic cl_sync2_q, cl_sync2_d;
    logic cl_prev_q,  cl_prev_d;

    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              carry_q, carry_d;
    logic              valid_q, valid_d;
    logic [7:0]        count_q, count_d;
    logic [2:0]        state_q, state_d;
    logic [3:0]        wait_q, wait_d;

    logic ld_pulse;
    logic cl_pulse;

    assign ld_pulse = ld_sync2_q & ~ld_prev_q;
    assign cl_pulse = cl_sync2_q & ~cl_prev_q;

    always_comb begin
        ld_sync1_d = btn_load;
        ld_sync2_d = ld_sync1_q;
        ld_prev_d  = ld_sync2_q;
        cl_sync1_d = btn_clear;
        cl_sync2_d = cl_sync1_q;
        cl_prev_d  = cl_sync2_q;
        a_d        = a_q;
        b_d        = b_q;
        sel_d      = sel_q;
        res_d      = res_q;
        carry_d    = carry_q;
        valid_d    = valid_q;
        count_d    = count_q;
        state_d    = state_q;
        wait_d     = wait_q;

        // Clear has priority; a coincident load pulse is simply lost.
        if (cl_pulse) begin
            a_d     = '0;
            b_d     = '0;
            sel_d   = '0;
            res_d   = '0;
            carry_d = 1'b0;
            valid_d = 1'b0;
            wait_d  = '0;
            state_d = LOAD_A;
        end else begin
            case (state_q)
                LOAD_A: begin
                    if (ld_pulse) begin
                        a_d     = sw;
                        valid_d = 1'b0;
                        state_d = LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (ld_pulse) begin
                        b_d     = sw;
                        state_d = LOAD_SEL;
                    end
                end
                LOAD_SEL: begin
                    if (ld_pulse) begin
                        sel_d   = sw[SEL_W-1:0];
                        wait_d  = WAIT_INIT;
                        state_d = EXEC;
                    end
                end
                EXEC: begin
                    // Load pulses are ignored here rather than queued.
                    if (wait_q == 4'd0) begin
                        res_d   = ALU_Out;
                        carry_d = CarryOut;
                        valid_d = 1'b1;
                        count_d = count_q + 8'd1;
                        state_d = DONE;
                    end else begin
                        wait_d = wait_q - 4'd1;
                    end
                end
                DONE: begin
                    if (ld_pulse) begin
                        state_d = LOAD_A;
                    end
                end
                default: begin
                    state_d = LOAD_A;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_sync1_q <= 1'b0;
            ld_sync2_q <= 1'b0;
            ld_prev_q  <= 1'b0;
            cl_sync1_q <= 1'b0;
            cl_sync2_q <= 1'b0;
            cl_prev_q  <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            sel_q      <= '0;
            res_q      <= '0;
            carry_q    <= 1'b0;
            valid_q    <= 1'b0;
            count_q    <= '0;
            state_q    <= LOAD_A;
            wait_q     <= '0;
        end else begin
            ld_sync1_q <= ld_sync1_d;
            ld_sync2_q <= ld_sync2_d;
            ld_prev_q  <= ld_prev_d;
            cl_sync1_q <= cl_sync1_d;
            cl_sync2_q <= cl_sync2_d;
            cl_prev_q  <= cl_prev_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sel_q      <= sel_d;
            res_q      <= res_d;
            carry_q    <= carry_d;
            valid_q    <= valid_d;
            count_q    <= count_d;
            state_q    <= state_d;
            wait_q     <= wait_d;
        end
    end

    assign A            = a_q;
    assign B            = b_q;
    assign ALU_Sel      = sel_q;
    assign result       = res_q;
    assign result_carry = carry_q;
    assign result_valid = valid_q;
    assign op_count     = count_q;
    assign state        = state_q;
    assign busy         = (state_q == EXEC);

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: three sequencers (ALU_LAT 1, 4, 8) each with an ALU
// model, driven by button presses and compared against an operation model.
module tb_alu_cmd_sequencer;

    logic       clk;
    logic       rst;
    logic [7:0] sw;
    logic       bl   [3];
    logic       bc   [3];
    logic [7:0] alu_o[3];
    logic       co   [3];
    logic [7:0] ao   [3];
    logic [7:0] bo   [3];
    logic [3:0] selo [3];
    logic [7:0] reso [3];
    logic       rco  [3];
    logic       rvo  [3];
    logic [7:0] cnto [3];
    logic [2:0] sto  [3];
    logic       busyo[3];

    int checks;
    int errors;
    int exp_cnt[3];

    function automatic logic [8:0] alu_ref(logic [7:0] a, logic [7:0] b,
                                           logic [3:0] s);
        logic [8:0] sum9;
        logic [7:0] r;
        sum9 = {1'b0, a} + {1'b0, b};
        case (s)
            4'd0: r = a + b;
            4'd1: r = a - b;
            4'd2: r = a * b;
            4'd3: r = (b == 8'd0) ? 8'd0 : a / b;
            4'd4: r = a << 1;
            4'd5: r = a >> 1;
            4'd6: r = {a[6:0], a[7]};
            4'd7: r = {a[0], a[7:1]};
            default: r = 8'h00;
        endcase
        return {sum9[8], r};
    endfunction

    function automatic int lat_of(int d);
        return (d == 0) ? 1 : (d == 1) ? 4 : 8;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : (g == 1) ? 4 : 8;
        assign {co[g], alu_o[g]} = alu_ref(ao[g], bo[g], selo[g]);
        alu_cmd_sequencer #(
            .DATA_W (8),
            .SEL_W  (4),
            .ALU_LAT(LAT)
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .sw          (sw),
            .btn_load    (bl[g]),
            .btn_clear   (bc[g]),
            .ALU_Out     (alu_o[g]),
            .CarryOut    (co[g]),
            .A           (ao[g]),
            .B           (bo[g]),
            .ALU_Sel     (selo[g]),
            .result      (reso[g]),
            .result_carry(rco[g]),
            .result_valid(rvo[g]),
            .op_count    (cnto[g]),
            .state       (sto[g]),
            .busy        (busyo[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic press(int d, logic [7:0] v);
        sw    = v;
        bl[d] = 1'b1;
        repeat (4) @(negedge clk);
        bl[d] = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic pulse_clear(int d, bit with_load, logic [7:0] v);
        sw    = v;
        bc[d] = 1'b1;
        if (with_load) bl[d] = 1'b1;
        repeat (4) @(negedge clk);
        bc[d] = 1'b0;
        bl[d] = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Third press: counts EXEC cycles; tog re-pulses the button during EXEC.
    task automatic exec_press(int d, logic [7:0] v, bit tog, output int n,
                              output logic [2:0] s2, output logic [2:0] s3,
                              output int bad);
        logic [7:0] a0;
        logic [7:0] b0;
        a0    = ao[d];
        b0    = bo[d];
        sw    = v;
        bl[d] = 1'b1;
        n     = 0;
        bad   = 0;
        s2    = 3'd7;
        s3    = 3'd7;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (i == 1) s2 = sto[d];
            if (i == 2) s3 = sto[d];
            if (sto[d] == 3'd3) begin
                n++;
                if (busyo[d] !== 1'b1 || ao[d] !== a0 || bo[d] !== b0)
                    bad++;
            end
            if (tog) bl[d] = (i == 1 || i == 3);
        end
        bl[d] = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic run_op(int d, logic [7:0] a, logic [7:0] b,
                          logic [7:0] s, bit tog);
        logic [8:0] r;
        logic [7:0] pa;
        logic [2:0] s2;
        logic [2:0] s3;
        int n;
        int bad;
        if (sto[d] == 3'd4) begin
            pa = ao[d];
            press(d, 8'h5A);
            checks++;
            if (sto[d] !== 3'd0 || rvo[d] !== 1'b1 || ao[d] !== pa) begin
                errors++;
                $display("FAIL done_to_a d%0d st=%0d valid=%0b A=%h exp st=0 valid=1 A=%h",
                         d, sto[d], rvo[d], ao[d], pa);
            end
        end
        press(d, a);
        checks++;
        if (sto[d] !== 3'd1 || ao[d] !== a || rvo[d] !== 1'b0) begin
            errors++;
            $display("FAIL load_a d%0d st=%0d A=%h valid=%0b exp st=1 A=%h valid=0",
                     d, sto[d], ao[d], rvo[d], a);
        end
        press(d, b);
        checks++;
        if (sto[d] !== 3'd2 || bo[d] !== b) begin
            errors++;
            $display("FAIL load_b d%0d st=%0d B=%h exp st=2 B=%h",
                     d, sto[d], bo[d], b);
        end
        exec_press(d, s, tog, n, s2, s3, bad);
        exp_cnt[d] = (exp_cnt[d] + 1) % 256;
        r = alu_ref(a, b, s[3:0]);
        checks++;
        if (s2 !== 3'd2 || s3 !== 3'd3) begin
            errors++;
            $display("FAIL pulse_edge d%0d st@2=%0d st@3=%0d exp 2 and 3",
                     d, s2, s3);
        end
        checks++;
        if (n != lat_of(d) || bad != 0) begin
            errors++;
            $display("FAIL exec_len d%0d cycles=%0d bad=%0d exp cycles=%0d bad=0",
                     d, n, bad, lat_of(d));
        end
        checks++;
        if (sto[d] !== 3'd4 || busyo[d] !== 1'b0) begin
            errors++;
            $display("FAIL done_st d%0d st=%0d busy=%0b exp st=4 busy=0",
                     d, sto[d], busyo[d]);
        end
        checks++;
        if (selo[d] !== s[3:0] || ao[d] !== a || bo[d] !== b) begin
            errors++;
            $display("FAIL operands d%0d sel=%h A=%h B=%h exp %h %h %h",
                     d, selo[d], ao[d], bo[d], s[3:0], a, b);
        end
        checks++;
        if (reso[d] !== r[7:0] || rco[d] !== r[8] || rvo[d] !== 1'b1) begin
            errors++;
            $display("FAIL result d%0d res=%h c=%0b v=%0b exp res=%h c=%0b v=1",
                     d, reso[d], rco[d], rvo[d], r[7:0], r[8]);
        end
        checks++;
        if (cnto[d] !== 8'(exp_cnt[d])) begin
            errors++;
            $display("FAIL op_count d%0d got %0d exp %0d",
                     d, cnto[d], exp_cnt[d]);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        sw  = 8'h00;
        for (int d = 0; d < 3; d++) begin
            bl[d] = 1'b0;
            bc[d] = 1'b0;
            exp_cnt[d] = 0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (ao[d] !== 8'h0 || bo[d] !== 8'h0 || selo[d] !== 4'h0 ||
                reso[d] !== 8'h0 || rco[d] !== 1'b0 || rvo[d] !== 1'b0 ||
                cnto[d] !== 8'h0 || sto[d] !== 3'd0 || busyo[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset d%0d A=%h B=%h sel=%h res=%h v=%0b cnt=%0d st=%0d exp all 0",
                         d, ao[d], bo[d], selo[d], reso[d], rvo[d], cnto[d], sto[d]);
            end
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_lat1;
        run_op(0, 8'h0F, 8'h01, 8'h00, 1'b0);
        checks++;
        if (reso[0] !== 8'h10 || rco[0] !== 1'b0 || cnto[0] !== 8'd1) begin
            errors++;
            $display("FAIL add_0f_01 res=%h c=%0b cnt=%0d exp 10 0 1",
                     reso[0], rco[0], cnto[0]);
        end
        run_op(0, 8'hFF, 8'h01, 8'h00, 1'b0);
        checks++;
        if (reso[0] !== 8'h00 || rco[0] !== 1'b1) begin
            errors++;
            $display("FAIL add_ff_01 res=%h c=%0b exp 00 1", reso[0], rco[0]);
        end
        run_op(0, 8'h14, 8'h05, 8'hA3, 1'b0);
        checks++;
        if (reso[0] !== 8'h04 || selo[0] !== 4'h3) begin
            errors++;
            $display("FAIL div_14_05 res=%h sel=%h exp 04 3", reso[0], selo[0]);
        end
        for (int i = 0; i < 4; i++)
            run_op(0, 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
    endtask

    task automatic test_drop;
        logic [7:0] x;
        logic [7:0] pb;
        run_op(1, 8'($urandom), 8'($urandom), 8'($urandom), 1'b1);
        run_op(1, 8'($urandom), 8'($urandom), 8'($urandom), 1'b1);
        press(1, 8'hC3);
        checks++;
        if (sto[1] !== 3'd0) begin
            errors++;
            $display("FAIL drop_to_a st=%0d exp 0", sto[1]);
        end
        x  = 8'($urandom);
        pb = bo[1];
        sw = x;
        bl[1] = 1'b1;
        repeat (50) @(negedge clk);
        checks++;
        if (sto[1] !== 3'd1 || ao[1] !== x || bo[1] !== pb) begin
            errors++;
            $display("FAIL hold_load st=%0d A=%h B=%h exp st=1 A=%h B=%h",
                     sto[1], ao[1], bo[1], x, pb);
        end
        bl[1] = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_clear;
        pulse_clear(1, 1'b0, 8'h99);
        checks++;
        if (sto[1] !== 3'd0 || ao[1] !== 8'h0 || cnto[1] !== 8'(exp_cnt[1])) begin
            errors++;
            $display("FAIL clear_b st=%0d A=%h cnt=%0d exp 0 00 %0d",
                     sto[1], ao[1], cnto[1], exp_cnt[1]);
        end
        for (int k = 0; k < 2; k++) begin
            press(1, 8'h33);
            press(1, 8'h44);
            checks++;
            if (sto[1] !== 3'd2 || ao[1] !== 8'h33 || bo[1] !== 8'h44) begin
                errors++;
                $display("FAIL pre_clear k%0d st=%0d A=%h B=%h exp 2 33 44",
                         k, sto[1], ao[1], bo[1]);
            end
            pulse_clear(1, k == 1, 8'h07);
            checks++;
            if (sto[1] !== 3'd0 || ao[1] !== 8'h0 || bo[1] !== 8'h0 ||
                selo[1] !== 4'h0 || reso[1] !== 8'h0 || rvo[1] !== 1'b0 ||
                cnto[1] !== 8'(exp_cnt[1])) begin
                errors++;
                $display("FAIL clear_sel k%0d st=%0d A=%h B=%h sel=%h res=%h v=%0b cnt=%0d exp 0 0 0 0 0 0 %0d",
                         k, sto[1], ao[1], bo[1], selo[1], reso[1], rvo[1],
                         cnto[1], exp_cnt[1]);
            end
        end
    endtask

    task automatic test_rst_exec;
        press(2, 8'h21);
        press(2, 8'h12);
        sw    = 8'h01;
        bl[2] = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (sto[2] !== 3'd3) begin
            errors++;
            $display("FAIL rst_pre st=%0d exp 3", sto[2]);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (ao[2] !== 8'h0 || bo[2] !== 8'h0 || selo[2] !== 4'h0 ||
            reso[2] !== 8'h0 || rvo[2] !== 1'b0 || sto[2] !== 3'd0 ||
            busyo[2] !== 1'b0 || cnto[0] !== 8'h0) begin
            errors++;
            $display("FAIL rst_async A=%h B=%h sel=%h res=%h v=%0b st=%0d busy=%0b cnt0=%0d exp all 0",
                     ao[2], bo[2], selo[2], reso[2], rvo[2], sto[2], busyo[2], cnto[0]);
        end
        @(negedge clk);
        bl[2] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 3; d++) exp_cnt[d] = 0;
        repeat (12) @(negedge clk);
        checks++;
        if (sto[2] !== 3'd0 || rvo[2] !== 1'b0 || reso[2] !== 8'h0 ||
            cnto[2] !== 8'h0) begin
            errors++;
            $display("FAIL rst_after st=%0d v=%0b res=%h cnt=%0d exp 0 0 00 0",
                     sto[2], rvo[2], reso[2], cnto[2]);
        end
    endtask

    task automatic test_wrap;
        for (int i = 0; i < 256; i++)
            run_op(0, 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
        checks++;
        if (cnto[0] !== 8'h00 || rvo[0] !== 1'b1) begin
            errors++;
            $display("FAIL wrap cnt=%0d v=%0b exp 0 1", cnto[0], rvo[0]);
        end
    endtask

    task automatic test_bad_state;
        press(0, 8'h11);
        @(negedge clk);
        force g_dut[0].u_dut.state_q = 3'd7;
        #1;
        release g_dut[0].u_dut.state_q;
        @(negedge clk);
        checks++;
        if (sto[0] !== 3'd0) begin
            errors++;
            $display("FAIL bad_state st=%0d exp 0", sto[0]);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_lat1();
        test_drop();
        test_clear();
        test_rst_exec();
        test_wrap();
        test_bad_state();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
